uart_baud_ctrl: RTL and testbench

Run-time controller for the UART baud tick path. It holds the active baud divisor and generates the 16x oversample tick and the 1x bit tick. It accepts new divisor values over a valid/ready config port. A divisor change is deferred until neither the TX nor the RX engine is mid-frame, so a rate change never corrupts a character.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_baud_counter.sv | 51 +++++
 rtl/uart_baud_ctrl.sv | 95 +++++++++
 tb/tb_uart_baud_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART baud tick path.
package uart_pkg;

   typedef enum logic [1:0] {
      BAUD_OFF,
      BAUD_RUN,
      BAUD_PEND,
      BAUD_APPLY
   } baud_state_e;

   localparam int OVERSAMPLE = 16;
   localparam int SUB_W      = $clog2(OVERSAMPLE);

endpackage

// File: rtl/uart_baud_counter.sv
// Divide-by-D oversample counter plus divide-by-16 sub counter.
// Emits registered one-cycle tick16/tick1 pulses.
module uart_baud_counter
   import uart_pkg::*;
#(
   parameter int DVSR_W = 16
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              run,
   input  logic              clear,
   input  logic [DVSR_W-1:0] dvsr,
   output logic              tick16,
   output logic              tick1
);

   logic [DVSR_W-1:0] cnt;
   logic [SUB_W-1:0]  sub;
   logic              cnt_wrap;
   logic              sub_wrap;

   // dvsr is never 0 here, so dvsr-1 cannot underflow.
   assign cnt_wrap = (cnt == dvsr - DVSR_W'(1));
   assign sub_wrap = (sub == SUB_W'(OVERSAMPLE - 1));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt    <= '0;
         sub    <= '0;
         tick16 <= 1'b0;
         tick1  <= 1'b0;
      end else begin
         tick16 <= 1'b0;
         tick1  <= 1'b0;
         if (clear) begin
            cnt <= '0;
            sub <= '0;
         end else if (run) begin
            if (cnt_wrap) begin
               cnt    <= '0;
               tick16 <= 1'b1;
               tick1  <= sub_wrap;
               sub    <= sub_wrap ? '0 : sub + 1'b1;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/uart_baud_ctrl.sv
// Baud tick controller: holds the active divisor, accepts new divisors and
// defers each change until neither UART engine is mid-frame.
module uart_baud_ctrl
   import uart_pkg::*;
#(
   parameter int SYS_FREQ     = 100000000,
   parameter int BAUD_RATE    = 9600,
   parameter int DVSR_W       = 16,
   parameter int DEFAULT_DVSR = SYS_FREQ / (OVERSAMPLE * BAUD_RATE)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [DVSR_W-1:0] cfg_dvsr,
   output logic              cfg_err,
   input  logic              tx_busy,
   input  logic              rx_busy,
   output logic              tick16,
   output logic              tick1,
   output logic [DVSR_W-1:0] dvsr_active
);

   generate
      if (DEFAULT_DVSR <= 0 || longint'(DEFAULT_DVSR) >= (longint'(1) << DVSR_W)) begin : g_bad_dvsr
         $error("uart_baud_ctrl: DEFAULT_DVSR is zero or does not fit DVSR_W");
      end
   endgenerate

   baud_state_e       state;
   baud_state_e       state_nxt;
   logic [DVSR_W-1:0] pending;
   logic              xfer;
   logic              xfer_zero;
   logic              xfer_ok;
   logic              cnt_run;
   logic              cnt_clear;

   assign cfg_ready = (state == BAUD_OFF) || (state == BAUD_RUN);
   assign xfer      = cfg_valid && cfg_ready;
   assign xfer_zero = xfer && (cfg_dvsr == '0);
   assign xfer_ok   = xfer && !xfer_zero;

   // An accepted divisor in RUN wins over a simultaneous en drop; PEND then
   // sees en low and still commits it through APPLY.
   always_comb begin
      state_nxt = state;
      case (state)
         BAUD_OFF:   if (en) state_nxt = BAUD_RUN;
         BAUD_RUN: begin
            if (xfer_ok)  state_nxt = BAUD_PEND;
            else if (!en) state_nxt = BAUD_OFF;
         end
         BAUD_PEND:  if (!en || (!tx_busy && !rx_busy)) state_nxt = BAUD_APPLY;
         BAUD_APPLY: state_nxt = en ? BAUD_RUN : BAUD_OFF;
         default:    state_nxt = BAUD_OFF;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= BAUD_OFF;
         dvsr_active <= DVSR_W'(DEFAULT_DVSR);
         pending     <= '0;
         cfg_err     <= 1'b0;
      end else begin
         state   <= state_nxt;
         cfg_err <= xfer_zero;
         if (state == BAUD_OFF && xfer_ok)
            dvsr_active <= cfg_dvsr;
         if (state == BAUD_RUN && xfer_ok)
            pending <= cfg_dvsr;
         if (state == BAUD_APPLY)
            dvsr_active <= pending;
      end
   end

   // Counting stops the same cycle en drops, so no tick is issued from then on.
   assign cnt_run   = en && (state == BAUD_RUN || state == BAUD_PEND);
   assign cnt_clear = !en || state == BAUD_OFF || state == BAUD_APPLY;

   uart_baud_counter #(
      .DVSR_W (DVSR_W)
   ) u_counter (
      .clk     (clk),
      .reset_n (reset_n),
      .run     (cnt_run),
      .clear   (cnt_clear),
      .dvsr    (dvsr_active),
      .tick16  (tick16),
      .tick1   (tick1)
   );

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Directed bench for uart_baud_ctrl; expected tick cycles are queued up front
// and a negedge monitor pops and compares them as the DUT ticks.
module tb_uart_baud_ctrl;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        en;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [15:0] cfg_dvsr;
   logic        cfg_err;
   logic        tx_busy;
   logic        rx_busy;
   logic        tick16;
   logic        tick1;
   logic [15:0] dvsr_active;

   int cyc    = 0;
   int checks = 0;
   int errors = 0;
   int q16[$];
   int q1[$];
   int mon_e16;
   int mon_e1;
   int c0;
   int c1;

   uart_baud_ctrl dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .en          (en),
      .cfg_valid   (cfg_valid),
      .cfg_ready   (cfg_ready),
      .cfg_dvsr    (cfg_dvsr),
      .cfg_err     (cfg_err),
      .tx_busy     (tx_busy),
      .rx_busy     (rx_busy),
      .tick16      (tick16),
      .tick1       (tick1),
      .dvsr_active (dvsr_active)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Expected ticks for a run entered at edge 'base' with divisor d, up to cycle 'upto'.
   task automatic plan(input int base, input int d, input int upto);
      for (int k = 1; base + k * d <= upto; k++) begin
         q16.push_back(base + k * d);
         if (k % 16 == 0) q1.push_back(base + k * d);
      end
   endtask

   task automatic drain(input string tag);
      wait_n(3);
      chk({tag, "_tick16_missing"}, q16.size(), 0);
      chk({tag, "_tick1_missing"}, q1.size(), 0);
      q16.delete();
      q1.delete();
   endtask

   always @(negedge clk) begin
      if (tick16 === 1'b1) begin
         mon_e16 = (q16.size() > 0) ? q16.pop_front() : -1;
         chk("tick16_cycle", cyc, mon_e16);
      end
      if (tick1 === 1'b1) begin
         mon_e1 = (q1.size() > 0) ? q1.pop_front() : -1;
         chk("tick1_cycle", cyc, mon_e1);
      end
   end

   initial begin
      reset_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_dvsr = '0;
      tx_busy = 1'b0; rx_busy = 1'b0;
      wait_n(3);
      chk("rst_dvsr", dvsr_active, 651);
      chk("rst_ready", cfg_ready, 1);
      chk("rst_tick16", tick16, 0);
      chk("rst_tick1", tick1, 0);
      chk("rst_err", cfg_err, 0);
      reset_n = 1'b1;
      wait_n(2);

      // default divisor
      c0 = cyc;
      plan(c0 + 1, 651, c0 + 10420);
      en = 1'b1;
      wait_n(100);
      chk("def_dvsr", dvsr_active, 651);
      wait_n(10320);
      en = 1'b0;
      drain("default");

      // load 4 while OFF, then run
      cfg_dvsr = 16'd4; cfg_valid = 1'b1;
      wait_n(1);
      cfg_valid = 1'b0;
      chk("off_load_dvsr", dvsr_active, 4);
      chk("off_ready", cfg_ready, 1);
      c0 = cyc;
      plan(c0 + 1, 4, c0 + 140);
      en = 1'b1;
      wait_n(140);
      en = 1'b0;
      drain("d4");

      // deferred change 4 -> 8 held off by tx_busy
      c0 = cyc;
      plan(c0 + 1, 4, c0 + 53);
      plan(c0 + 54, 8, c0 + 214);
      en = 1'b1; tx_busy = 1'b1;
      wait_n(21);
      cfg_dvsr = 16'd8; cfg_valid = 1'b1;
      wait_n(1);
      cfg_valid = 1'b0;
      chk("pend_ready", cfg_ready, 0);
      wait_n(30);
      chk("pend_ready_hold", cfg_ready, 0);
      chk("pend_dvsr_old", dvsr_active, 4);
      tx_busy = 1'b0;
      wait_n(1);
      chk("apply_ready", cfg_ready, 0);
      chk("apply_dvsr_old", dvsr_active, 4);
      wait_n(1);
      chk("applied_dvsr", dvsr_active, 8);
      chk("applied_ready", cfg_ready, 1);
      wait_n(160);
      en = 1'b0;
      drain("defer");

      // zero divisor rejected in RUN
      c0 = cyc;
      plan(c0 + 1, 8, c0 + 100);
      en = 1'b1;
      wait_n(10);
      chk("err_idle", cfg_err, 0);
      cfg_dvsr = 16'd0; cfg_valid = 1'b1;
      wait_n(1);
      cfg_valid = 1'b0;
      chk("err_pulse", cfg_err, 1);
      chk("err_ready", cfg_ready, 1);
      chk("err_dvsr", dvsr_active, 8);
      wait_n(1);
      chk("err_clear", cfg_err, 0);
      chk("err_ready2", cfg_ready, 1);
      wait_n(88);
      en = 1'b0;
      drain("zero");

      // reset while PEND
      cfg_dvsr = 16'd4; cfg_valid = 1'b1;
      wait_n(1);
      cfg_valid = 1'b0;
      chk("rp_load", dvsr_active, 4);
      c0 = cyc;
      plan(c0 + 1, 4, c0 + 20);
      tx_busy = 1'b1; en = 1'b1;
      wait_n(10);
      cfg_dvsr = 16'd8; cfg_valid = 1'b1;
      wait_n(1);
      cfg_valid = 1'b0;
      chk("rp_pend", cfg_ready, 0);
      wait_n(9);
      reset_n = 1'b0; en = 1'b0;
      wait_n(1);
      reset_n = 1'b1; tx_busy = 1'b0;
      chk("rp_dvsr", dvsr_active, 651);
      chk("rp_ready", cfg_ready, 1);
      chk("rp_tick16", tick16, 0);
      chk("rp_tick1", tick1, 0);
      wait_n(20);
      chk("rp_dvsr_hold", dvsr_active, 651);
      drain("rst_pend");

      // en drop while PEND with rx_busy
      cfg_dvsr = 16'd4; cfg_valid = 1'b1;
      wait_n(1);
      cfg_valid = 1'b0;
      chk("ep_load", dvsr_active, 4);
      c0 = cyc;
      plan(c0 + 1, 4, c0 + 30);
      rx_busy = 1'b1; en = 1'b1;
      wait_n(10);
      cfg_dvsr = 16'd6; cfg_valid = 1'b1;
      wait_n(1);
      cfg_valid = 1'b0;
      chk("ep_pend", cfg_ready, 0);
      wait_n(19);
      en = 1'b0;
      wait_n(1);
      chk("ep_apply_ready", cfg_ready, 0);
      chk("ep_apply_dvsr", dvsr_active, 4);
      wait_n(1);
      chk("ep_off_dvsr", dvsr_active, 6);
      chk("ep_off_ready", cfg_ready, 1);
      wait_n(20);
      drain("en_pend");
      c1 = cyc;
      plan(c1 + 1, 6, c1 + 100);
      en = 1'b1;
      wait_n(100);
      en = 1'b0; rx_busy = 1'b0;
      drain("d6");

      // load D=1 together with en rising
      c0 = cyc;
      plan(c0 + 1, 1, c0 + 40);
      cfg_dvsr = 16'd1; cfg_valid = 1'b1; en = 1'b1;
      wait_n(1);
      cfg_valid = 1'b0;
      chk("d1_dvsr", dvsr_active, 1);
      wait_n(39);
      en = 1'b0;
      drain("d1");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
